// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: round-robin ALU/MEM writeback arbiter driving a registered
// register-file write port, with a per-register busy scoreboard for RAW hazards.
module regfile_wb_ctrl #(
    parameter int DW   = 8,
    parameter int AW   = 3,
    parameter int NREG = 2**AW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_addr,
    input  logic [DW-1:0]   alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_data,
    output logic            mem_ready,
    input  logic            rsv_valid,
    input  logic [AW-1:0]   rsv_addr,
    input  logic [AW-1:0]   chk_addr1,
    input  logic [AW-1:0]   chk_addr2,
    output logic            hazard,
    output logic            regwrite,
    output logic [AW-1:0]   wa,
    output logic [DW-1:0]   wd,
    output logic [NREG-1:0] busy,
    output logic            err
);
    typedef enum logic {LAST_MEM, LAST_ALU} rr_t;
    rr_t rr, rr_next;
    logic gnt_alu, gnt_mem;
    logic [NREG-1:0] set_mask, clr_mask;
    always_comb begin
        gnt_alu  = !rst && alu_valid && (!mem_valid || rr == LAST_MEM);
        gnt_mem  = !rst && mem_valid && (!alu_valid || rr == LAST_ALU);
        rr_next  = gnt_alu ? LAST_ALU : gnt_mem ? LAST_MEM : rr;
        set_mask = rsv_valid ? NREG'(1) << rsv_addr : '0;
        clr_mask = regwrite ? NREG'(1) << wa : '0;
    end
    assign alu_ready = gnt_alu;
    assign mem_ready = gnt_mem;
    assign hazard    = busy[chk_addr1] | busy[chk_addr2];
    // a reservation landing on its own commit edge is newer, so set beats clear
    always_ff @(posedge clk) begin
        if (rst) begin
            rr       <= LAST_MEM;
            regwrite <= 1'b0;
            wa       <= '0;
            wd       <= '0;
            busy     <= '0;
            err      <= 1'b0;
        end else begin
            rr       <= rr_next;
            regwrite <= gnt_alu | gnt_mem;
            if (gnt_alu | gnt_mem) begin
                wa <= gnt_alu ? alu_addr : mem_addr;
                wd <= gnt_alu ? alu_data : mem_data;
            end
            busy <= (busy & ~clr_mask) | set_mask;
            err  <= err | (regwrite & ~busy[wa]);
        end
    end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: vector table, directed corner sequences and random traffic
// against a behavioural model of arbitration, scoreboard and register file.
module tb_regfile_wb_ctrl;
    logic clk = 1'b0;
    logic rst, alu_valid, mem_valid, rsv_valid;
    logic [2:0] alu_addr, mem_addr, rsv_addr, chk_addr1, chk_addr2, wa;
    logic [7:0] alu_data, mem_data, wd, busy;
    logic alu_ready, mem_ready, hazard, regwrite, err;
    logic [7:0] rf_dut [8] = '{default: 8'h00};

    always #5 clk = ~clk;

    regfile_wb_ctrl dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .hazard(hazard),
        .regwrite(regwrite), .wa(wa), .wd(wd), .busy(busy), .err(err)
    );

    // the 8x8 register file the controller feeds
    always @(posedge clk) if (regwrite) rf_dut[wa] <= wd;

    typedef struct {
        bit rst; bit av; bit [2:0] aa; bit [7:0] ad;
        bit mv; bit [2:0] ma; bit [7:0] md;
        bit rv; bit [2:0] ra; bit [2:0] c1; bit [2:0] c2;
    } in_t;

    typedef struct {
        in_t i;
        bit ar; bit mr; bit hz; bit rw; bit [2:0] wa; bit [7:0] wd; bit [7:0] busy; bit err;
    } row_t;

    int n_pass = 0, n_tot = 0;

    bit       m_alu_turn = 1'b1;
    bit       m_rw = 1'b0;
    bit [2:0] m_wa = '0;
    bit [7:0] m_wd = '0;
    bit       m_busy [8] = '{default: 1'b0};
    bit       m_err = 1'b0;
    bit [7:0] m_rf [8] = '{default: 8'h00};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic in_t z();
        in_t t;
        t = '{default: 0};
        return t;
    endfunction

    function automatic row_t r(input bit rs, av, input bit [2:0] aa, input bit [7:0] ad,
                               input bit mv, input bit [2:0] ma, input bit [7:0] md,
                               input bit rv, input bit [2:0] ra, c1, c2,
                               input bit ar, mr, hz, rw, input bit [2:0] ewa,
                               input bit [7:0] ewd, eb, input bit ee);
        row_t x;
        x.i = '{rs, av, aa, ad, mv, ma, md, rv, ra, c1, c2};
        x.ar = ar; x.mr = mr; x.hz = hz; x.rw = rw; x.wa = ewa; x.wd = ewd; x.busy = eb; x.err = ee;
        return x;
    endfunction

    // 0 = no grant, 1 = ALU, 2 = MEM
    function automatic int pick(input in_t i);
        if (i.rst) return 0;
        if (i.av && (!i.mv || m_alu_turn)) return 1;
        if (i.mv) return 2;
        return 0;
    endfunction

    task automatic drive(input in_t i);
        rst = i.rst; alu_valid = i.av; alu_addr = i.aa; alu_data = i.ad;
        mem_valid = i.mv; mem_addr = i.ma; mem_data = i.md;
        rsv_valid = i.rv; rsv_addr = i.ra; chk_addr1 = i.c1; chk_addr2 = i.c2;
    endtask

    task automatic model_edge(input in_t i, input int win);
        if (m_rw) m_rf[m_wa] = m_wd;
        if (i.rst) begin
            m_rw = 0; m_wa = 0; m_wd = 0; m_err = 0; m_alu_turn = 1;
            foreach (m_busy[k]) m_busy[k] = 0;
        end else begin
            if (m_rw) begin
                if (!m_busy[m_wa]) m_err = 1;
                m_busy[m_wa] = 0;
            end
            if (i.rv) m_busy[i.ra] = 1;
            m_rw = (win != 0);
            if (win == 1) begin m_wa = i.aa; m_wd = i.ad; m_alu_turn = 0; end
            if (win == 2) begin m_wa = i.ma; m_wd = i.md; m_alu_turn = 1; end
        end
    endtask

    task automatic step(input in_t i, output int win);
        logic [7:0] bv;
        drive(i);
        win = pick(i);
        @(negedge clk);
        foreach (m_busy[k]) bv[k] = m_busy[k];
        chk("alu_ready", alu_ready, 32'(win == 1));
        chk("mem_ready", mem_ready, 32'(win == 2));
        chk("hazard", hazard, 32'(m_busy[i.c1] | m_busy[i.c2]));
        chk("regwrite", regwrite, 32'(m_rw));
        chk("wa", wa, 32'(m_wa));
        chk("wd", wd, 32'(m_wd));
        chk("busy", busy, 32'(bv));
        chk("err", err, 32'(m_err));
        @(posedge clk);
        model_edge(i, win);
        #1;
    endtask

    initial begin
        row_t rows [$];
        in_t t;
        int w;
        bit ap, mp;
        drive(z());
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        rows.push_back(r(1,1,5,8'hAA,0,0,0,   0,0,0,0, 0,0,0,0,0,8'h00,8'h00,0));
        rows.push_back(r(0,0,0,0,    0,0,0,   1,4,4,0, 0,0,0,0,0,8'h00,8'h00,0));
        rows.push_back(r(0,1,4,8'h17,0,0,0,   0,0,4,0, 1,0,1,0,0,8'h00,8'h10,0));
        rows.push_back(r(0,0,0,0,    0,0,0,   0,0,4,0, 0,0,1,1,4,8'h17,8'h10,0));
        rows.push_back(r(0,0,0,0,    0,0,0,   0,0,4,0, 0,0,0,0,4,8'h17,8'h00,0));
        rows.push_back(r(0,1,1,8'h11,1,2,8'h22,0,0,0,0, 0,1,0,0,4,8'h17,8'h00,0));
        rows.push_back(r(0,1,1,8'h11,0,0,0,   0,0,0,0, 1,0,0,1,2,8'h22,8'h00,0));
        rows.push_back(r(0,0,0,0,    0,0,0,   0,0,0,0, 0,0,0,1,1,8'h11,8'h00,1));
        rows.push_back(r(0,0,0,0,    0,0,0,   0,0,0,0, 0,0,0,0,1,8'h11,8'h00,1));
        rows.push_back(r(1,1,3,8'h33,0,0,0,   0,0,0,0, 0,0,0,0,1,8'h11,8'h00,1));
        rows.push_back(r(0,0,0,0,    0,0,0,   0,0,0,0, 0,0,0,0,0,8'h00,8'h00,0));
        foreach (rows[n]) begin
            drive(rows[n].i);
            w = pick(rows[n].i);
            @(negedge clk);
            chk($sformatf("row%0d alu_ready", n), alu_ready, 32'(rows[n].ar));
            chk($sformatf("row%0d mem_ready", n), mem_ready, 32'(rows[n].mr));
            chk($sformatf("row%0d hazard", n), hazard, 32'(rows[n].hz));
            chk($sformatf("row%0d regwrite", n), regwrite, 32'(rows[n].rw));
            chk($sformatf("row%0d wa", n), wa, 32'(rows[n].wa));
            chk($sformatf("row%0d wd", n), wd, 32'(rows[n].wd));
            chk($sformatf("row%0d busy", n), busy, 32'(rows[n].busy));
            chk($sformatf("row%0d err", n), err, 32'(rows[n].err));
            @(posedge clk);
            model_edge(rows[n].i, w);
            #1;
        end
        chk("tbl_rf4", rf_dut[4], 32'h17);

        // same-register collision, r3 reserved twice (second on the ALU commit edge)
        t = z(); t.rst = 1; step(t, w);
        t = z(); t.rv = 1; t.ra = 3; step(t, w);
        t = z(); t.av = 1; t.aa = 3; t.ad = 8'h05; t.mv = 1; t.ma = 3; t.md = 8'h09; step(t, w);
        t.av = 0; t.rv = 1; t.ra = 3; step(t, w);
        t = z(); step(t, w);
        chk("coll2_busy3_cleared", busy[3], 0);
        step(t, w);
        chk("coll2_rf3", rf_dut[3], 32'h09);
        chk("coll2_err", err, 0);

        // same-register collision without reservation
        t = z(); t.rst = 1; step(t, w);
        t = z(); t.av = 1; t.aa = 3; t.ad = 8'h05; t.mv = 1; t.ma = 3; t.md = 8'h09; step(t, w);
        t.av = 0; step(t, w);
        t = z(); step(t, w); step(t, w);
        chk("coll1_rf3", rf_dut[3], 32'h09);
        chk("coll1_err", err, 1);

        // hazard on r6, with a re-reservation on the commit edge
        t = z(); t.rst = 1; step(t, w);
        t = z(); t.c1 = 6; t.rv = 1; t.ra = 6; step(t, w);
        t = z(); t.c1 = 6; t.mv = 1; t.ma = 6; t.md = 8'h40; step(t, w);
        t = z(); t.c1 = 6; t.rv = 1; t.ra = 6; step(t, w);
        chk("haz_busy6_held", busy[6], 1);
        chk("haz_still", hazard, 1);
        t = z(); t.c1 = 6; t.mv = 1; t.ma = 6; t.md = 8'h41; step(t, w);
        t = z(); t.c1 = 6; step(t, w);
        chk("haz_clear", hazard, 0);
        step(t, w);
        chk("haz_rf6", rf_dut[6], 32'h41);

        // sticky error, cleared only by reset
        t = z(); t.av = 1; t.aa = 7; t.ad = 8'h77; step(t, w);
        t = z(); step(t, w);
        chk("err_set", err, 1);
        t = z(); t.mv = 1; t.ma = 1; t.md = 8'h01; step(t, w);
        t = z(); step(t, w); step(t, w);
        chk("err_sticky", err, 1);
        t = z(); t.rst = 1; step(t, w);
        chk("err_reset", err, 0);

        // reset the cycle after an ALU grant, MEM keeps its request up throughout
        t = z(); t.rv = 1; t.ra = 5; step(t, w);
        t = z(); t.av = 1; t.aa = 5; t.ad = 8'h55; t.mv = 1; t.ma = 6; t.md = 8'h66; step(t, w);
        t.av = 0; t.rst = 1; step(t, w);
        chk("rst_regwrite", regwrite, 0);
        chk("rst_busy", busy, 0);
        t.rst = 0; drive(t); #1;
        chk("rst_mem_regrant", mem_ready, 1);
        step(t, w);
        t = z(); step(t, w);

        // random traffic; requesters hold until granted
        t = z(); ap = 0; mp = 0;
        for (int n = 0; n < 400; n++) begin
            t.rst = ($urandom_range(0, 49) == 0);
            if (!ap && $urandom_range(0, 2) == 0) begin
                ap = 1; t.aa = 3'($urandom); t.ad = 8'($urandom);
            end
            if (!mp && $urandom_range(0, 2) == 0) begin
                mp = 1; t.ma = 3'($urandom); t.md = 8'($urandom);
            end
            t.av = ap; t.mv = mp;
            t.rv = ($urandom_range(0, 3) == 0); t.ra = 3'($urandom);
            t.c1 = 3'($urandom); t.c2 = 3'($urandom);
            step(t, w);
            if (w == 1) ap = 0;
            if (w == 2) mp = 0;
        end
        t = z(); step(t, w); step(t, w);
        for (int k = 0; k < 8; k++) chk($sformatf("rand_rf%0d", k), rf_dut[k], 32'(m_rf[k]));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
